buf_min_reduce: RTL and testbench
=================================

// Module: buf_min_reduce
// PURPOSE
//  Reduction stage downstream of the multicore array. After every worker core raises buf_flag, it
//  scans the per-core result buffers one core per cycle through the existing 6-bit address/select mux.
//  It returns the minimum buf_val_1 (score), the paired buf_val_2 (packed location) and the winning
//  core index, so the master core needs no software compare loop.
// PARAMETERS
//  NUM_CORES     61      worker cores scanned, indices 0..NUM_CORES-1 (1..64)
//  ADDR_W        6       width of scan address, >= clog2(NUM_CORES)
//  TIMEOUT       1023    cycles in WAIT_FLAGS before aborting with err; 0 = no timeout
// PORTS
//  Clk           in   1       rising-edge clock
//  Reset_n       in   1       asynchronous, active-low reset
//  start         in   1       1-cycle pulse from master: begin a reduction
//  all_buf_flags in   1       AND of all worker buf_flag bits
//  scan_addr     out  ADDR_W  core index driven onto the buf_val_1/buf_val_2 select mux
//  val_1_sel     in   32      buf_val_1 of core scan_addr (combinational, same cycle)
//  val_2_sel     in   32      buf_val_2 of core scan_addr (combinational, same cycle)
//  busy          out  1       high in WAIT_FLAGS and SCAN
//  done          out  1       1-cycle pulse: result valid
//  err           out  1       sticky timeout flag, cleared by next accepted start
//  best_val_1    out  32      minimum score
//  best_val_2    out  32      buf_val_2 of the winning core
//  best_idx      out  ADDR_W  index of the winning core
// BEHAVIOUR
//  Reset (async, Reset_n=0): state=IDLE; scan_addr, best_*, busy, done, err, timer = 0.
//    Reset mid-scan aborts with no done pulse.
//  States: IDLE -> WAIT_FLAGS -> SCAN -> DONE -> IDLE.
//  IDLE: start=1 -> WAIT_FLAGS. Clear err and timer; set scan_addr=0 and best_val_1=32'hFFFF_FFFF.
//  WAIT_FLAGS:
//   - all_buf_flags=1 -> SCAN on the next cycle.
//   - Otherwise timer++. If TIMEOUT!=0 and timer reaches TIMEOUT: set err=1 and return to IDLE.
//     No done pulse; best_* keep their cleared values.
//  SCAN: each cycle, compare val_1_sel with best_val_1 (unsigned).
//   - Strictly less: load best_val_1, best_val_2 and best_idx=scan_addr.
//   - At scan_addr=0 the load is unconditional, so the result is always a real core.
//   - Ties keep the lower index.
//   - Increment scan_addr. After index NUM_CORES-1 is compared -> DONE.
//   - scan_addr never exceeds NUM_CORES-1 (no wrap into unused mux slots).
//  DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
//    best_* stay held until the next accepted start.
//  Latency: start to done = 1 + W + NUM_CORES + 1 cycles, where W = cycles waiting for flags
//    (W=0 gives 63 for 61 cores).
//  start while busy=1 or in DONE: ignored.
//  all_buf_flags is sampled only in WAIT_FLAGS. Deassertion during SCAN is ignored and does not
//    restart the scan.
//  Outputs are registered. Only the compare path uses the combinational val_*_sel inputs.
// TESTING
//  1. Reset: hold Reset_n=0 mid-SCAN -> all outputs 0, state IDLE immediately (async), no done.
//  2. Basic min: core k scores 1000+k, core 17 = 5, val_2 = k<<8.
//     -> best_val_1=5, best_val_2=0x1100, best_idx=17, done at cycle 63 after start.
//  3. Ties: cores 4, 9 and 60 all score 0 -> best_idx=4.
//     All cores 32'hFFFF_FFFF -> best_idx=0, best_val_1=32'hFFFF_FFFF.
//  4. Flag wait: raise all_buf_flags 10 cycles after start -> done 73 cycles after start; busy high
//     throughout.
//  5. Timeout: TIMEOUT=8, flags never set -> err=1 at cycle 9, no done. Next start clears err.
//  6. Busy start: pulse start during SCAN and in the DONE cycle -> no restart, exactly one done,
//     result unchanged. Drop flags mid-scan -> result unchanged.

Source files
------------

// File: rtl/buf_min_reduce_if.sv
// Handshake and result bus between the master core / result-buffer mux and the
// buf_min_reduce stage.
interface buf_min_reduce_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              all_buf_flags;
    logic [ADDR_W-1:0] scan_addr;
    logic [31:0]       val_1_sel;
    logic [31:0]       val_2_sel;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       best_val_1;
    logic [31:0]       best_val_2;
    logic [ADDR_W-1:0] best_idx;

    // The master side also owns the buffer mux, so it returns val_*_sel for scan_addr.
    modport master (
        output start, all_buf_flags, val_1_sel, val_2_sel,
        input  scan_addr, busy, done, err, best_val_1, best_val_2, best_idx
    );

    modport slave (
        input  start, all_buf_flags, val_1_sel, val_2_sel,
        output scan_addr, busy, done, err, best_val_1, best_val_2, best_idx
    );
endinterface

// File: rtl/buf_min_reduce.sv
// Minimum-score reduction over the per-core result buffers: waits for every worker
// flag, scans one core per cycle and reports the lowest buf_val_1 with its pair and index.
module buf_min_reduce #(
    parameter int NUM_CORES = 61,
    parameter int ADDR_W    = 6,
    parameter int TIMEOUT   = 1023
) (
    input  logic                Clk,
    input  logic                Reset_n,
    buf_min_reduce_if.slave     bus
);

    localparam int              TMR_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              HAS_TIMEOUT = (TIMEOUT != 0);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_CORES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FLAGS,
        SCAN,
        DONE
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [ADDR_W-1:0] scan_addr;
    logic [31:0]       best_val_1;
    logic [31:0]       best_val_2;
    logic [ADDR_W-1:0] best_idx;
    logic              busy;
    logic              done;
    logic              err;

    // Core 0 always loads so the result names a real core even if every score is all-ones.
    logic take;
    assign take = (scan_addr == '0) || (bus.val_1_sel < best_val_1);

    // NOTE: the asynchronous reset lives in the sensitivity list so a reset mid-scan
    // clears the outputs at once, without waiting for a clock edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            scan_addr  <= '0;
            best_val_1 <= '0;
            best_val_2 <= '0;
            best_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the
            // pre-edge value of the state registers regardless of statement order.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= WAIT_FLAGS;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        timer      <= '0;
                        scan_addr  <= '0;
                        best_val_1 <= '1;
                        best_val_2 <= '0;
                        best_idx   <= '0;
                    end
                end

                WAIT_FLAGS: begin
                    if (bus.all_buf_flags) begin
                        state <= SCAN;
                    end else begin
                        timer <= timer + 1'b1;
                        if (HAS_TIMEOUT && (timer == TMR_LAST)) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                SCAN: begin
                    if (take) begin
                        best_val_1 <= bus.val_1_sel;
                        best_val_2 <= bus.val_2_sel;
                        best_idx   <= scan_addr;
                    end
                    // Hold on the last core rather than wrapping into unused mux slots.
                    if (scan_addr == ADDR_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        scan_addr <= scan_addr + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.scan_addr  = scan_addr;
    assign bus.best_val_1 = best_val_1;
    assign bus.best_val_2 = best_val_2;
    assign bus.best_idx   = best_idx;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.err        = err;

endmodule

// File: tb/tb_buf_min_reduce.sv
// Directed bench for buf_min_reduce: reset, minimum search, ties, flag wait,
// timeout and ignored starts, each compared against hand-computed values.
module tb_buf_min_reduce;

    logic Clk = 1'b0;
    logic Reset_n;

    always #5 Clk = ~Clk;

    buf_min_reduce_if #(.ADDR_W(6)) bus ();
    buf_min_reduce_if #(.ADDR_W(6)) bus_t ();

    buf_min_reduce #(.NUM_CORES(61), .ADDR_W(6), .TIMEOUT(1023)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    buf_min_reduce #(.NUM_CORES(61), .ADDR_W(6), .TIMEOUT(8)) dut_t (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus_t.slave)
    );

    // Result-buffer model: the mux returns the selected core's words combinationally.
    logic [31:0] score [64];
    logic [31:0] loc   [64];

    assign bus.val_1_sel   = score[bus.scan_addr];
    assign bus.val_2_sel   = loc[bus.scan_addr];
    assign bus_t.val_1_sel = score[bus_t.scan_addr];
    assign bus_t.val_2_sel = loc[bus_t.scan_addr];

    int         n_cmp = 0;
    int         n_err = 0;
    int         done_count = 0;
    int         done_t_count = 0;
    logic [5:0] max_addr = '0;

    always @(negedge Clk) begin
        if (bus.done === 1'b1) done_count++;
        if (bus_t.done === 1'b1) done_t_count++;
        if (bus.scan_addr > max_addr) max_addr = bus.scan_addr;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask

    // Cycle number counts from the start cycle (0); returns the cycle in which done is seen.
    task automatic wait_done(input int from, output int lat, output bit busy_ok);
        lat     = from;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick;
            lat++;
        end
    endtask

    task automatic basic_scores;
        for (int k = 0; k < 64; k++) begin
            score[k] = 32'd1000 + 32'(k);
            loc[k]   = 32'(k) << 8;
        end
        score[17] = 32'd5;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit busy_ok;
        bit busy_wait_ok;
        int dc0;

        Reset_n             = 1'b0;
        bus.start           = 1'b0;
        bus.all_buf_flags   = 1'b0;
        bus_t.start         = 1'b0;
        bus_t.all_buf_flags = 1'b0;
        basic_scores();

        // Reset state
        #12;
        check("rst_scan_addr", 32'(bus.scan_addr), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_best_val_1", bus.best_val_1, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick;
        tick;

        // Basic minimum: core 17 scores 5
        bus.all_buf_flags = 1'b1;
        pulse_start();
        wait_done(1, lat, busy_ok);
        check("basic_latency", 32'(lat), 32'd63);
        check("basic_busy_during", 32'(busy_ok), 32'd1);
        check("basic_busy_at_done", 32'(bus.busy), 32'd0);
        check("basic_val_1", bus.best_val_1, 32'd5);
        check("basic_val_2", bus.best_val_2, 32'h0000_1100);
        check("basic_idx", 32'(bus.best_idx), 32'd17);
        check("basic_max_addr", 32'(max_addr), 32'd60);
        tick;
        check("basic_done_one_cycle", 32'(bus.done), 32'd0);
        check("basic_held_val_1", bus.best_val_1, 32'd5);

        // Ties at zero: lowest index wins
        for (int k = 0; k < 64; k++) score[k] = 32'd100;
        score[4]  = 32'd0;
        score[9]  = 32'd0;
        score[60] = 32'd0;
        pulse_start();
        wait_done(1, lat, busy_ok);
        check("tie_latency", 32'(lat), 32'd63);
        check("tie_idx", 32'(bus.best_idx), 32'd4);
        check("tie_val_1", bus.best_val_1, 32'd0);
        check("tie_val_2", bus.best_val_2, 32'h0000_0400);
        tick;

        // All scores all-ones: core 0 still reported
        for (int k = 0; k < 64; k++) score[k] = 32'hFFFF_FFFF;
        pulse_start();
        wait_done(1, lat, busy_ok);
        check("ones_idx", 32'(bus.best_idx), 32'd0);
        check("ones_val_1", bus.best_val_1, 32'hFFFF_FFFF);
        check("ones_val_2", bus.best_val_2, 32'd0);
        tick;

        // Flags raised after 10 waiting cycles
        basic_scores();
        bus.all_buf_flags = 1'b0;
        pulse_start();
        busy_wait_ok = 1'b1;
        repeat (10) begin
            if (bus.busy !== 1'b1) busy_wait_ok = 1'b0;
            tick;
        end
        bus.all_buf_flags = 1'b1;
        wait_done(11, lat, busy_ok);
        check("wait_latency", 32'(lat), 32'd73);
        check("wait_busy", 32'(busy_ok & busy_wait_ok), 32'd1);
        check("wait_val_1", bus.best_val_1, 32'd5);
        check("wait_idx", 32'(bus.best_idx), 32'd17);
        tick;

        // Starts during SCAN and DONE are ignored; flag drop mid-scan is ignored
        dc0 = done_count;
        pulse_start();
        lat = 1;
        while (lat < 63) begin
            bus.start         = (lat == 30);
            bus.all_buf_flags = !(lat >= 20 && lat < 40);
            tick;
            lat++;
        end
        bus.start         = 1'b0;
        bus.all_buf_flags = 1'b1;
        check("busy_done_at_63", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("busy_no_restart", 32'(bus.busy), 32'd0);
        repeat (70) tick;
        check("busy_single_done", 32'(done_count - dc0), 32'd1);
        check("busy_still_idle", 32'(bus.busy), 32'd0);
        check("busy_val_1", bus.best_val_1, 32'd5);
        check("busy_val_2", bus.best_val_2, 32'h0000_1100);
        check("busy_idx", 32'(bus.best_idx), 32'd17);

        // Timeout instance: TIMEOUT=8, flags never set
        bus_t.start = 1'b1;
        tick;
        bus_t.start = 1'b0;
        check("to_err_c1", 32'(bus_t.err), 32'd0);
        check("to_busy_c1", 32'(bus_t.busy), 32'd1);
        repeat (7) tick;
        check("to_err_c8", 32'(bus_t.err), 32'd0);
        check("to_busy_c8", 32'(bus_t.busy), 32'd1);
        tick;
        check("to_err_c9", 32'(bus_t.err), 32'd1);
        check("to_busy_c9", 32'(bus_t.busy), 32'd0);
        check("to_best_val_1", bus_t.best_val_1, 32'hFFFF_FFFF);
        repeat (3) tick;
        check("to_err_sticky", 32'(bus_t.err), 32'd1);
        check("to_no_done", 32'(done_t_count), 32'd0);
        bus_t.start = 1'b1;
        tick;
        bus_t.start = 1'b0;
        check("to_err_cleared", 32'(bus_t.err), 32'd0);

        // Asynchronous reset mid-scan
        pulse_start();
        repeat (20) tick;
        #2;
        Reset_n = 1'b0;
        #1;
        check("mid_rst_scan_addr", 32'(bus.scan_addr), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_best_val_1", bus.best_val_1, 32'd0);
        check("mid_rst_best_val_2", bus.best_val_2, 32'd0);
        check("mid_rst_best_idx", 32'(bus.best_idx), 32'd0);
        dc0 = done_count;
        repeat (3) tick;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (70) tick;
        check("mid_rst_no_done", 32'(done_count - dc0), 32'd0);
        check("mid_rst_idle", 32'(bus.busy), 32'd0);

        // Normal reduction after reset
        pulse_start();
        wait_done(1, lat, busy_ok);
        check("post_rst_latency", 32'(lat), 32'd63);
        check("post_rst_val_1", bus.best_val_1, 32'd5);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
